// File: rtl/cache_front_stage_pkg.sv
// Request type shared between cache stages and tree-PLRU helpers (up to 8 ways).
package rv32i_types;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } s1_s2_req_t;

  // Root node selects way bit 0, so leaves pair as {0,2,..} vs {1,3,..}.
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int unsigned lvls);
    logic [2:0] way;
    way    = '0;
    way[0] = bits[0];
    if (lvls > 1) way[1] = bits[3'd1 + {2'b00, way[0]}];
    if (lvls > 2) way[2] = bits[3'd3 + {1'b0, way[1:0]}];
    return way;
  endfunction

  function automatic logic [6:0] plru_update(input logic [6:0] bits, input logic [2:0] w,
                                             input int unsigned lvls);
    logic [6:0] nb;
    nb    = bits;
    nb[0] = ~w[0];
    if (lvls > 1) nb[3'd1 + {2'b00, w[0]}]  = ~w[1];
    if (lvls > 2) nb[3'd3 + {1'b0, w[1:0]}] = ~w[2];
    return nb;
  endfunction

endpackage

// File: rtl/cache_front_stage_plru.sv
// Per-set tree-PLRU state; a fill in the same set is applied after a hit.
module plru_tree import rv32i_types::*; #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hit_valid_i,
  input  logic [$clog2(SETS)-1:0] hit_set_i,
  input  logic [$clog2(WAYS)-1:0] hit_way_i,
  input  logic                    fill_valid_i,
  input  logic [$clog2(SETS)-1:0] fill_set_i,
  input  logic [$clog2(WAYS)-1:0] fill_way_i,
  input  logic [$clog2(SETS)-1:0] rd_set_i,
  output logic [$clog2(WAYS)-1:0] victim_o
);

  localparam int unsigned SW   = $clog2(SETS);
  localparam int unsigned WW   = $clog2(WAYS);
  localparam int unsigned LVLS = $clog2(WAYS);

  logic [6:0] bits_q [SETS];
  logic [6:0] bits_d [SETS];

  always_comb begin
    for (int unsigned s = 0; s < SETS; s++) begin
      bits_d[s] = bits_q[s];
      if (hit_valid_i && hit_set_i == SW'(s))
        bits_d[s] = plru_update(bits_d[s], 3'(hit_way_i), LVLS);
      if (fill_valid_i && fill_set_i == SW'(s))
        bits_d[s] = plru_update(bits_d[s], 3'(fill_way_i), LVLS);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SETS; s++) bits_q[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < SETS; s++) bits_q[s] <= bits_d[s];
    end
  end

  assign victim_o = WW'(plru_victim(bits_q[rd_set_i], LVLS));

endmodule

// File: rtl/cache_front_stage.sv
// Cache stage 1: request register, one-entry store buffer, SRAM write-port arbitration, PLRU.
module cache_front_stage import rv32i_types::*; #(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned SETS      = 16,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ufp_valid,
  input  logic [31:0]              ufp_addr,
  input  logic [3:0]               ufp_rmask,
  input  logic [3:0]               ufp_wmask,
  input  logic [31:0]              ufp_wdata,
  output logic                     ufp_ready,
  output logic                     s2_valid,
  output s1_s2_req_t               s2_req,
  input  logic                     s2_stall,
  input  logic                     hit_valid,
  input  logic [$clog2(SETS)-1:0]  hit_set,
  input  logic [$clog2(WAYS)-1:0]  hit_way,
  output logic [$clog2(WAYS)-1:0]  victim_way,
  input  logic                     st_valid,
  input  logic [$clog2(SETS)-1:0]  st_set,
  input  logic [$clog2(WAYS)-1:0]  st_way,
  input  logic [LINE_BITS/8-1:0]   st_mask,
  input  logic [LINE_BITS-1:0]     st_data,
  input  logic                     dfp_resp,
  input  logic [LINE_BITS-1:0]     dfp_rdata,
  input  logic [$clog2(SETS)-1:0]  dfp_set,
  input  logic [$clog2(WAYS)-1:0]  dfp_way,
  input  logic                     dfp_drop,
  output logic [31:0]              sram_addr  [WAYS],
  output logic                     sram_web   [WAYS],
  output logic [LINE_BITS/8-1:0]   sram_wmask [WAYS],
  output logic [LINE_BITS-1:0]     sram_din   [WAYS],
  output logic                     valid_in   [WAYS],
  output logic                     dirty_in   [WAYS]
);

  localparam int unsigned MB  = LINE_BITS / 8;
  localparam int unsigned OFS = $clog2(MB);
  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned WW  = $clog2(WAYS);

  s1_s2_req_t           s2_req_q;
  logic                 s2_valid_q;
  logic                 sb_valid_q;
  logic [IDX-1:0]       sb_set_q;
  logic [WW-1:0]        sb_way_q;
  logic [MB-1:0]        sb_mask_q;
  logic [LINE_BITS-1:0] sb_data_q;

  logic                 fill, commit, merge, pend_v, accept, capture, hold_addr;
  logic [IDX-1:0]       pend_set;
  logic [WW-1:0]        pend_way;
  logic [MB-1:0]        pend_mask;
  logic [LINE_BITS-1:0] pend_data, fill_din;

  assign fill      = rst && dfp_resp && !dfp_drop;
  assign commit    = sb_valid_q && !fill;
  assign ufp_ready = rst && !s2_stall && !sb_valid_q && !dfp_resp;
  assign accept    = ufp_valid && ufp_ready;
  assign hold_addr = s2_stall || dfp_resp || commit;

  // A fill merges with the buffered store, or with a store arriving in the same cycle.
  assign pend_v    = sb_valid_q || st_valid;
  assign pend_set  = sb_valid_q ? sb_set_q  : st_set;
  assign pend_way  = sb_valid_q ? sb_way_q  : st_way;
  assign pend_mask = sb_valid_q ? sb_mask_q : st_mask;
  assign pend_data = sb_valid_q ? sb_data_q : st_data;
  assign merge     = fill && pend_v && (pend_set == dfp_set) && (pend_way == dfp_way);
  assign capture   = st_valid && !(merge && !sb_valid_q) && (!sb_valid_q || commit || merge);

  always_comb begin
    fill_din = dfp_rdata;
    if (merge) begin
      for (int unsigned b = 0; b < MB; b++)
        if (pend_mask[b]) fill_din[b*8 +: 8] = pend_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_req_q   <= '0;
    end else if (!s2_stall) begin
      s2_valid_q <= accept;
      if (accept)
        s2_req_q <= '{addr: ufp_addr, rmask: ufp_rmask, wmask: ufp_wmask, wdata: ufp_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid_q <= 1'b0;
      sb_set_q   <= '0;
      sb_way_q   <= '0;
      sb_mask_q  <= '0;
      sb_data_q  <= '0;
    end else if (capture) begin
      sb_valid_q <= 1'b1;
      sb_set_q   <= st_set;
      sb_way_q   <= st_way;
      sb_mask_q  <= st_mask;
      sb_data_q  <= st_data;
    end else if (commit || merge) begin
      sb_valid_q <= 1'b0;
    end
  end

  always_comb begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      sram_addr[w]  = hold_addr ? s2_req_q.addr : ufp_addr;
      sram_web[w]   = 1'b1;
      sram_wmask[w] = '0;
      sram_din[w]   = '0;
      valid_in[w]   = 1'b0;
      dirty_in[w]   = 1'b0;
      if (fill && dfp_way == WW'(w)) begin
        sram_web[w]   = 1'b0;
        sram_wmask[w] = '1;
        sram_din[w]   = fill_din;
        valid_in[w]   = 1'b1;
        dirty_in[w]   = merge;
      end else if (commit && sb_way_q == WW'(w)) begin
        sram_web[w]   = 1'b0;
        sram_wmask[w] = sb_mask_q;
        sram_din[w]   = sb_data_q;
        valid_in[w]   = 1'b1;
        dirty_in[w]   = 1'b1;
      end
    end
  end

  plru_tree #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk          (clk),
    .rst          (rst),
    .hit_valid_i  (hit_valid),
    .hit_set_i    (hit_set),
    .hit_way_i    (hit_way),
    .fill_valid_i (fill),
    .fill_set_i   (dfp_set),
    .fill_way_i   (dfp_way),
    .rd_set_i     (s2_req_q.addr[OFS+IDX-1:OFS]),
    .victim_o     (victim_way)
  );

  assign s2_req   = s2_req_q;
  assign s2_valid = s2_valid_q;

endmodule

// File: tb/tb_cache_front_stage.sv
// Bench for cache_front_stage: vector table plus request scoreboard and reset sequences.
module tb_cache_front_stage;
  import rv32i_types::*;

  localparam int unsigned WAYS = 4;
  localparam int unsigned SETS = 16;
  localparam int unsigned LB   = 256;
  localparam int unsigned MB   = LB / 8;

  localparam logic [LB-1:0] FILL   = {8{32'hDEAD_BEEF}};
  localparam logic [LB-1:0] STD    = {8{32'h1122_3344}};
  localparam logic [LB-1:0] MERGED = {{7{32'hDEAD_BEEF}}, 32'h1122_3344};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ufp_valid, ufp_ready, s2_valid, s2_stall;
  logic [31:0]   ufp_addr, ufp_wdata;
  logic [3:0]    ufp_rmask, ufp_wmask;
  s1_s2_req_t    s2_req;
  logic          hit_valid, st_valid, dfp_resp, dfp_drop;
  logic [3:0]    hit_set, st_set, dfp_set;
  logic [1:0]    hit_way, st_way, dfp_way, victim_way;
  logic [MB-1:0] st_mask;
  logic [LB-1:0] st_data, dfp_rdata;
  logic [31:0]   sram_addr  [WAYS];
  logic          sram_web   [WAYS];
  logic [MB-1:0] sram_wmask [WAYS];
  logic [LB-1:0] sram_din   [WAYS];
  logic          valid_in   [WAYS];
  logic          dirty_in   [WAYS];

  cache_front_stage #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(LB)) dut (
    .clk(clk), .rst(rst),
    .ufp_valid(ufp_valid), .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask),
    .ufp_wdata(ufp_wdata), .ufp_ready(ufp_ready),
    .s2_valid(s2_valid), .s2_req(s2_req), .s2_stall(s2_stall),
    .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way), .victim_way(victim_way),
    .st_valid(st_valid), .st_set(st_set), .st_way(st_way), .st_mask(st_mask), .st_data(st_data),
    .dfp_resp(dfp_resp), .dfp_rdata(dfp_rdata), .dfp_set(dfp_set), .dfp_way(dfp_way),
    .dfp_drop(dfp_drop),
    .sram_addr(sram_addr), .sram_web(sram_web), .sram_wmask(sram_wmask), .sram_din(sram_din),
    .valid_in(valid_in), .dirty_in(dirty_in)
  );

  typedef struct {
    logic uv; logic [31:0] ua; logic stall;
    logic stv; logic [3:0] sts; logic [1:0] stw; logic [31:0] stm;
    logic dr; logic [3:0] ds; logic [1:0] dw; logic dd;
    logic hv; logic [3:0] hset; logic [1:0] hw;
    logic e_ready; logic [3:0] e_web; logic [31:0] e_addr; logic [1:0] e_vic;
    logic [3:0] e_vin; logic [3:0] e_dirty; logic [31:0] e_wm; logic [LB-1:0] e_din;
    logic e_s2v; logic [31:0] e_s2a;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  s1_s2_req_t sb_q[$];
  s1_s2_req_t sb_exp;
  logic hs = 1'b0;
  vec_t vt[$];

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mkv(
    input logic uv, input logic [31:0] ua, input logic stall,
    input logic stv, input logic [3:0] sts, input logic [1:0] stw, input logic [31:0] stm,
    input logic dr, input logic [3:0] ds, input logic [1:0] dw, input logic dd,
    input logic hv, input logic [3:0] hset, input logic [1:0] hw,
    input logic e_ready, input logic [3:0] e_web, input logic [31:0] e_addr, input logic [1:0] e_vic,
    input logic [3:0] e_vin, input logic [3:0] e_dirty, input logic [31:0] e_wm,
    input logic [LB-1:0] e_din, input logic e_s2v, input logic [31:0] e_s2a);
    vec_t v;
    v.uv = uv; v.ua = ua; v.stall = stall;
    v.stv = stv; v.sts = sts; v.stw = stw; v.stm = stm;
    v.dr = dr; v.ds = ds; v.dw = dw; v.dd = dd;
    v.hv = hv; v.hset = hset; v.hw = hw;
    v.e_ready = e_ready; v.e_web = e_web; v.e_addr = e_addr; v.e_vic = e_vic;
    v.e_vin = e_vin; v.e_dirty = e_dirty; v.e_wm = e_wm; v.e_din = e_din;
    v.e_s2v = e_s2v; v.e_s2a = e_s2a;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ufp_valid = v.uv; ufp_addr = v.ua; ufp_rmask = 4'hF; ufp_wmask = 4'h0;
    ufp_wdata = v.ua ^ 32'h5555_0000; s2_stall = v.stall;
    st_valid = v.stv; st_set = v.sts; st_way = v.stw; st_mask = v.stm; st_data = STD;
    dfp_resp = v.dr; dfp_set = v.ds; dfp_way = v.dw; dfp_drop = v.dd; dfp_rdata = FILL;
    hit_valid = v.hv; hit_set = v.hset; hit_way = v.hw;
    if (v.uv && v.e_ready)
      sb_q.push_back('{addr: v.ua, rmask: 4'hF, wmask: 4'h0, wdata: v.ua ^ 32'h5555_0000});
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic [3:0] web, vin, dty;
    for (int w = 0; w < WAYS; w++) begin
      web[w] = sram_web[w]; vin[w] = valid_in[w]; dty[w] = dirty_in[w];
    end
    chk($sformatf("v%0d ready", i), ufp_ready, v.e_ready);
    chk($sformatf("v%0d web", i), web, v.e_web);
    chk($sformatf("v%0d valid_in", i), vin, v.e_vin);
    chk($sformatf("v%0d dirty_in", i), dty, v.e_dirty);
    chk($sformatf("v%0d victim", i), victim_way, v.e_vic);
    chk($sformatf("v%0d s2_valid", i), s2_valid, v.e_s2v);
    chk($sformatf("v%0d s2_addr", i), s2_req.addr, v.e_s2a);
    for (int w = 0; w < WAYS; w++) begin
      chk($sformatf("v%0d addr%0d", i, w), sram_addr[w], v.e_addr);
      chk($sformatf("v%0d din%0d", i, w), sram_din[w], v.e_web[w] ? '0 : v.e_din);
      chk($sformatf("v%0d wmask%0d", i, w), sram_wmask[w], v.e_web[w] ? '0 : v.e_wm);
    end
  endtask

  always @(posedge clk) hs = rst && ufp_valid && ufp_ready;

  always @(negedge clk) begin
    if (hs) begin
      hs = 1'b0;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_accept", 1'b1, 1'b0);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_s2_valid", s2_valid, 1'b1);
        chk("sb_s2_req", s2_req, sb_exp);
      end
    end
  end

  initial begin
    // uv ua stall | stv sts stw stm | dr ds dw dd | hv hs hw || ready web addr vic vin dirty wm din s2v s2a
    vt.push_back(mkv(1, 32'h40, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'h40,0, 0,0,0,'0, 0,32'h0));
    vt.push_back(mkv(0, 32'h80, 1, 0,0,0,0, 0,0,0,0, 0,0,0, 0,4'hF,32'h40,0, 0,0,0,'0, 1,32'h40));
    vt.push_back(mkv(1, 32'h80, 1, 0,0,0,0, 0,0,0,0, 0,0,0, 0,4'hF,32'h40,0, 0,0,0,'0, 1,32'h40));
    vt.push_back(mkv(1, 32'h80, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'h80,0, 0,0,0,'0, 1,32'h40));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 1,4,2,0, 0,0,0, 0,4'hB,32'h80,0, 4'h4,0,32'hFFFF_FFFF,FILL, 1,32'h80));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'h0,1, 0,0,0,'0, 0,32'h80));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 1,4,1,1, 0,0,0, 0,4'hF,32'h80,1, 0,0,0,'0, 0,32'h80));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'h0,1, 0,0,0,'0, 0,32'h80));
    vt.push_back(mkv(0, 32'h0, 0, 1,3,1,32'hF0, 0,0,0,0, 0,0,0, 1,4'hF,32'h0,1, 0,0,0,'0, 0,32'h80));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,4'hD,32'h80,1, 4'h2,4'h2,32'hF0,STD, 0,32'h80));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'h0,1, 0,0,0,'0, 0,32'h80));
    vt.push_back(mkv(0, 32'h0, 0, 1,3,1,32'hF, 1,3,1,0, 0,0,0, 0,4'hD,32'h80,1, 4'h2,4'h2,32'hFFFF_FFFF,MERGED, 0,32'h80));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'h0,1, 0,0,0,'0, 0,32'h80));
    vt.push_back(mkv(1, 32'hA0, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'hA0,1, 0,0,0,'0, 0,32'h80));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 1,5,0, 1,4'hF,32'h0,0, 0,0,0,'0, 1,32'hA0));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 1,5,1, 1,4'hF,32'h0,1, 0,0,0,'0, 0,32'hA0));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 1,5,2, 1,4'hF,32'h0,2, 0,0,0,'0, 0,32'hA0));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'h0,3, 0,0,0,'0, 0,32'hA0));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 1,5,3,0, 0,0,0, 0,4'h7,32'hA0,3, 4'h8,0,32'hFFFF_FFFF,FILL, 0,32'hA0));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'h0,0, 0,0,0,'0, 0,32'hA0));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 1,5,2,0, 1,5,1, 0,4'hB,32'hA0,0, 4'h4,0,32'hFFFF_FFFF,FILL, 0,32'hA0));
    vt.push_back(mkv(0, 32'h0, 0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,4'hF,32'h0,3, 0,0,0,'0, 0,32'hA0));

    rst = 1'b0;
    drive(mkv(0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,'0, 0,0));
    repeat (2) @(posedge clk);
    #1 dfp_resp = 1'b1; dfp_way = 2'd2;
    @(negedge clk);
    chk("rst s2_valid", s2_valid, 1'b0);
    chk("rst s2_req", s2_req, '0);
    chk("rst victim", victim_way, 2'd0);
    for (int w = 0; w < WAYS; w++) begin
      chk($sformatf("rst web%0d", w), sram_web[w], 1'b1);
      chk($sformatf("rst valid_in%0d", w), valid_in[w], 1'b0);
      chk($sformatf("rst dirty_in%0d", w), dirty_in[w], 1'b0);
    end
    @(posedge clk);
    #1 dfp_resp = 1'b0; rst = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      @(negedge clk);
      check_vec(i, vt[i]);
      @(posedge clk);
      #1;
    end

    // Fill the store buffer, then pulse reset mid-cycle before it can commit.
    st_valid = 1'b1; st_set = 4'd6; st_way = 2'd0; st_mask = 32'hFF;
    @(posedge clk);
    #1 st_valid = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2 s2_valid", s2_valid, 1'b0);
    chk("rst2 victim", victim_way, 2'd0);
    for (int w = 0; w < WAYS; w++) chk($sformatf("rst2 web%0d", w), sram_web[w], 1'b1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    drive(mkv(1,32'h1C0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 1,0,0,0, 0,0,0,'0, 0,0));
    @(negedge clk);
    chk("post ready", ufp_ready, 1'b1);
    chk("post victim", victim_way, 2'd0);
    for (int w = 0; w < WAYS; w++) chk($sformatf("post web%0d", w), sram_web[w], 1'b1);
    @(posedge clk);
    #1 ufp_valid = 1'b0;
    @(negedge clk);
    chk("post s2_addr", s2_req.addr, 32'h1C0);
    for (int w = 0; w < WAYS; w++) chk($sformatf("post2 web%0d", w), sram_web[w], 1'b1);
    @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_front_stage.md
CACHE_FRONT_STAGE -- requirements
Module: cache_front_stage

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity; power of two, 2..8.
REQ-002 SHALL have parameter SETS, default 16, sets per way; power of two; index = addr[OFS+IDX-1:OFS].
REQ-003 SHALL have parameter LINE_BITS, default 256, line width; OFS = log2(LINE_BITS/8).
REQ-004 SHALL have ports clk input 1 clock; rst input 1 reset (asynchronous, active-low).
REQ-005 SHALL have ports ufp_valid in 1; ufp_addr in 32; ufp_rmask in 4; ufp_wmask in 4; ufp_wdata in 32; ufp_ready out 1 (request accepted when valid&&ready).
REQ-006 SHALL have ports s2_valid out 1; s2_req out s1_s2_req_t (addr, rmask, wmask, wdata); s2_stall in 1 (stage 2 not consuming).
REQ-007 SHALL have ports hit_valid in 1; hit_set in log2(SETS); hit_way in log2(WAYS) (stage-2 hit report, updates PLRU).
REQ-008 SHALL have ports victim_way out log2(WAYS): PLRU victim for the set of s2_req.addr.
REQ-009 SHALL have ports st_valid in 1; st_set in log2(SETS); st_way in log2(WAYS); st_mask in LINE_BITS/8; st_data in LINE_BITS (store-hit write from stage 2).
REQ-010 SHALL have ports dfp_resp in 1; dfp_rdata in LINE_BITS; dfp_set in log2(SETS); dfp_way in log2(WAYS); dfp_drop in 1 (fill not to be installed).
REQ-011 SHALL have per-way arrays [WAYS] out: sram_addr 32, sram_web 1, sram_wmask LINE_BITS/8, sram_din LINE_BITS, valid_in 1, dirty_in 1.

Function
REQ-012 SHALL register accepted requests into s2_req/s2_valid one cycle after the handshake (latency 1); s2_req SHALL hold while s2_stall=1.
REQ-013 SHALL drive ufp_ready = !s2_stall && !(store buffer occupied) && !dfp_resp.
REQ-014 SHALL hold a one-entry store buffer; st_valid captures st_set/way/mask/data; committed to SRAM the next cycle unless a fill wins the port.
REQ-015 SHALL arbitrate SRAM write port per cycle, priority: fill (dfp_resp && !dfp_drop) > store-buffer commit > read lookup.
REQ-016 SHALL, on fill, write way dfp_way: web=0, wmask all ones, din=dfp_rdata, valid_in=1, dirty_in=0; other ways web=1.
REQ-017 SHALL, if fill and a pending store target same set and way, merge store bytes (st_mask) over dfp_rdata, set dirty_in=1, and free the buffer in that cycle.
REQ-018 SHALL, on store commit, write st_way with wmask=st_mask, din=st_data, valid_in=1, dirty_in=1.
REQ-019 SHALL drive sram_addr of all ways to the held s2_req.addr while s2_stall, dfp_resp, or a store commit is active; else ufp_addr.
REQ-020 SHALL keep per-set tree-PLRU state (WAYS-1 bits/set); hit_valid updates bits pointing away from hit_way; fill updates away from dfp_way; same cycle, same set: fill applied after hit.
REQ-021 SHALL compute victim_way combinationally from the PLRU bits of the s2_req set, following bits from root.
REQ-022 SHALL drive sram_wmask/din to zero on non-writing ways (no X outputs).

Reset
REQ-023 SHALL, while rst=0: s2_valid=0, s2_req=0, store buffer empty, all PLRU bits 0 (victim_way=0), all sram_web=1, valid_in=0, dirty_in=0.
REQ-024 SHALL discard an in-flight store buffer entry and held request on reset assertion mid-operation; first accept possible the cycle after rst deasserts.

Structure
REQ-025 SHALL place s1_s2_req_t and the PLRU victim/update functions in package rv32i_types.
REQ-026 SHALL implement PLRU state as one sub-module plru_tree (parameters WAYS, SETS).

Verification
REQ-027 Accept load 0x0000_0040, s2_stall=0 -> next cycle s2_valid=1, s2_req.addr=0x40, all sram_web=1.
REQ-028 s2_stall=1 two cycles with new ufp_addr 0x80 -> ufp_ready=0, sram_addr stays 0x40, s2_req unchanged.
REQ-029 dfp_resp, dfp_way=2, dfp_drop=0 -> only way 2 web=0, wmask all ones, valid_in=1, dirty_in=0.
REQ-030 st_valid (set 3, way 1, mask 0x0000000F) same cycle as dfp_resp (set 3, way 1) -> way 1 din = fill with low 4 bytes from st_data, dirty_in=1, buffer empty next cycle.
REQ-031 WAYS=4, set 5 hits ways 0,1,2 in order -> victim_way=3; then fill way 3 -> victim_way=0.
REQ-032 rst pulsed low while buffer full -> no store commit after release; victim_way=0.
